// File: rtl/seq_shift_pkg.sv
// Shared types for the sequential shift unit: operation codes and FSM states.
package seq_shift_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ASR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ROR  = 3'b110
  } op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift(input op_e op);
    return op inside {OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_ROR};
  endfunction

endpackage

// File: rtl/seq_shift_unit_step.sv
// Combinational single-bit step of a shift/rotate op; out_bit is the bit leaving the register.
module shift_step
  import seq_shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] value,
  input  op_e          op,
  input  logic         ls,
  input  logic         rs,
  output logic [N-1:0] nxt,
  output logic         out_bit
);

  always_comb begin
    nxt     = value;
    out_bit = 1'b0;
    case (op)
      OP_SHL: begin nxt = {value[N-2:0], ls};          out_bit = value[N-1]; end
      OP_SHR: begin nxt = {rs, value[N-1:1]};          out_bit = value[0];   end
      OP_ASR: begin nxt = {value[N-1], value[N-1:1]};  out_bit = value[0];   end
      OP_ROL: begin nxt = {value[N-2:0], value[N-1]};  out_bit = value[N-1]; end
      OP_ROR: begin nxt = {value[0], value[N-1:1]};    out_bit = value[0];   end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// N-bit register with load and multi-mode shift/rotate, one bit per clock,
// under a start/busy/done handshake.
module seq_shift_unit
  import seq_shift_pkg::*;
#(
  parameter  int N  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          set,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [N-1:0]  Reg_in,
  input  logic [SW-1:0] num_shift,
  input  logic          Ls,
  input  logic          Rs,
  output logic [N-1:0]  Reg_out,
  output logic          busy,
  output logic          done,
  output logic          carry,
  output logic          zero
);

  localparam logic [SW-1:0] MAX_SH = SW'(N - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  reg_q, reg_d;
  logic [SW-1:0] cnt_q, cnt_d;
  op_e           op_q, op_d;
  logic          ls_q, ls_d, rs_q, rs_d;
  logic          carry_q, carry_d, busy_q, busy_d, done_q, done_d;
  logic [SW-1:0] sh_amt;
  logic [N-1:0]  step_val;
  logic          step_out;
  op_e           op_in;

  // Counts above N-1 are only possible when N is not a power of two.
  assign sh_amt = (num_shift > MAX_SH) ? MAX_SH : num_shift;
  assign op_in  = op_e'(op);

  shift_step #(.N(N)) u_step (
    .value   (reg_q),
    .op      (op_q),
    .ls      (ls_q),
    .rs      (rs_q),
    .nxt     (step_val),
    .out_bit (step_out)
  );

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ls_d    = ls_q;
    rs_d    = rs_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op_in;
          ls_d  = Ls;
          rs_d  = Rs;
          cnt_d = sh_amt;
          if (op_in == OP_LOAD) begin
            reg_d   = Reg_in;
            carry_d = 1'b0;
            done_d  = 1'b1;
          end else if (is_shift(op_in)) begin
            if (sh_amt == '0) begin
              carry_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              busy_d  = 1'b1;
              state_d = S_SHIFT;
            end
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        reg_d   = step_val;
        carry_d = step_out;
        cnt_d   = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      reg_q   <= '0;
      cnt_q   <= '0;
      op_q    <= OP_HOLD;
      ls_q    <= 1'b0;
      rs_q    <= 1'b0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (!set) begin
      // Set overrides the FSM and aborts any shift without a done pulse.
      state_q <= S_IDLE;
      reg_q   <= '1;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ls_q    <= ls_d;
      rs_q    <= rs_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Reg_out = reg_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign carry   = carry_q;
  assign zero    = (reg_q == '0);

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit (N=8): inputs driven and outputs sampled on the falling edge.
module tb_seq_shift_unit;

  logic       clk = 1'b0;
  logic       clr, set, start, Ls, Rs;
  logic [2:0] op, num_shift;
  logic [7:0] Reg_in, Reg_out;
  logic       busy, done, carry, zero;
  int         checks = 0;
  int         errors = 0;

  seq_shift_unit #(.N(8)) dut (
    .clk(clk), .clr(clr), .set(set), .start(start), .op(op), .Reg_in(Reg_in),
    .num_shift(num_shift), .Ls(Ls), .Rs(Rs), .Reg_out(Reg_out), .busy(busy),
    .done(done), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge, then scramble the inputs to prove they were latched.
  task automatic kick(input logic [2:0] o, input logic [2:0] k, input logic l, input logic r,
                      input logic [7:0] d);
    op = o; num_shift = k; Ls = l; Rs = r; Reg_in = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'b001; Reg_in = ~d; num_shift = ~k; Ls = ~l; Rs = ~r;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [2:0] k,
                        input logic l, input logic r, input logic [7:0] d,
                        input int exp_lat, input logic [7:0] exp_reg, input logic exp_c);
    int lat;
    kick(o, k, l, r, d);
    chk({tag, "_busy1"}, busy, (exp_lat > 1));
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_reg"}, Reg_out, exp_reg);
    chk({tag, "_carry"}, carry, exp_c);
    chk({tag, "_busy0"}, busy, 1'b0);
    @(negedge clk);
    chk({tag, "_done1cyc"}, done, 1'b0);
  endtask

  initial begin
    int lat;
    logic saw;
    clr = 1'b0; set = 1'b1; start = 1'b0; op = 3'b000; num_shift = 3'd0;
    Ls = 1'b0; Rs = 1'b0; Reg_in = 8'h00;
    @(negedge clk); @(negedge clk);
    chk("rst_reg", Reg_out, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_carry", carry, 1'b0);
    chk("rst_zero", zero, 1'b1);
    clr = 1'b1;
    @(negedge clk);

    run_op("ld_b4",  3'b001, 3'd0, 1'b0, 1'b0, 8'hB4, 1, 8'hB4, 1'b0);
    chk("nz_zero", zero, 1'b0);
    run_op("shl3",   3'b010, 3'd3, 1'b1, 1'b0, 8'h00, 4, 8'hA7, 1'b1);
    run_op("ld_96",  3'b001, 3'd0, 1'b0, 1'b0, 8'h96, 1, 8'h96, 1'b0);
    run_op("asr2",   3'b100, 3'd2, 1'b0, 1'b0, 8'h00, 3, 8'hE5, 1'b1);
    run_op("shr7",   3'b011, 3'd7, 1'b0, 1'b0, 8'h00, 8, 8'h01, 1'b1);
    run_op("ld_81",  3'b001, 3'd0, 1'b0, 1'b0, 8'h81, 1, 8'h81, 1'b0);
    run_op("ror1",   3'b110, 3'd1, 1'b0, 1'b0, 8'h00, 2, 8'hC0, 1'b1);
    run_op("rol7",   3'b101, 3'd7, 1'b0, 1'b0, 8'h00, 8, 8'h60, 1'b0);
    chk("rol_popcnt", $countones(Reg_out), 2);
    run_op("ld_81b", 3'b001, 3'd0, 1'b0, 1'b0, 8'h81, 1, 8'h81, 1'b0);
    run_op("asr7a",  3'b100, 3'd7, 1'b0, 1'b0, 8'h00, 8, 8'hFF, 1'b0);
    run_op("ld_7f",  3'b001, 3'd0, 1'b0, 1'b0, 8'h7F, 1, 8'h7F, 1'b0);
    run_op("asr7b",  3'b100, 3'd7, 1'b0, 1'b0, 8'h00, 8, 8'h00, 1'b1);
    chk("asr7b_zero", zero, 1'b1);

    // start while busy must be ignored
    run_op("ld_0f",  3'b001, 3'd0, 1'b0, 1'b0, 8'h0F, 1, 8'h0F, 1'b0);
    kick(3'b010, 3'd2, 1'b0, 1'b0, 8'h00);
    op = 3'b110; num_shift = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("ign_lat", lat, 3);
    chk("ign_reg", Reg_out, 8'h3C);
    chk("ign_carry", carry, 1'b0);
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      saw |= done | busy;
    end
    chk("ign_noqueue", saw, 1'b0);
    chk("ign_reg_hold", Reg_out, 8'h3C);

    // synchronous set aborts a shift
    kick(3'b101, 3'd5, 1'b0, 1'b0, 8'h00);
    set = 1'b0;
    @(negedge clk);
    set = 1'b1;
    chk("set_reg", Reg_out, 8'hFF);
    chk("set_busy", busy, 1'b0);
    chk("set_carry", carry, 1'b0);
    chk("set_done", done, 1'b0);
    saw = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      saw |= done;
    end
    chk("set_nodone", saw, 1'b0);

    // asynchronous clear mid-shift, between clock edges
    run_op("ld_3c",  3'b001, 3'd0, 1'b0, 1'b0, 8'h3C, 1, 8'h3C, 1'b0);
    kick(3'b101, 3'd5, 1'b0, 1'b0, 8'h00);
    @(negedge clk); @(negedge clk);
    #1 clr = 1'b0;
    #1;
    chk("clr_reg", Reg_out, 8'h00);
    chk("clr_busy", busy, 1'b0);
    chk("clr_zero", zero, 1'b1);
    #1 clr = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      saw |= done;
    end
    chk("clr_nodone", saw, 1'b0);
    chk("clr_reg_hold", Reg_out, 8'h00);

    // zero-count shift, reserved op, back-to-back start in the done cycle
    run_op("ld_a5",  3'b001, 3'd0, 1'b0, 1'b0, 8'hA5, 1, 8'hA5, 1'b0);
    run_op("shl1",   3'b010, 3'd1, 1'b0, 1'b0, 8'h00, 2, 8'h4A, 1'b1);
    run_op("shr0",   3'b011, 3'd0, 1'b1, 1'b1, 8'h00, 1, 8'h4A, 1'b0);
    run_op("rsvd",   3'b111, 3'd3, 1'b1, 1'b1, 8'hFF, 1, 8'h4A, 1'b0);
    kick(3'b010, 3'd1, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("b2b_done", done, 1'b1);
    chk("b2b_reg1", Reg_out, 8'h95);
    run_op("b2b_ror1", 3'b110, 3'd1, 1'b0, 1'b0, 8'h00, 2, 8'hCA, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
